// File: rtl/pe_sequencer_pkg.sv
// Shared definitions for the pe frame sequencer: FSM state encoding,
// channel byte offsets inside a packed {r,g,b} word and the default
// timeout for a pe done state.
package pe_defs;

    typedef enum logic [3:0] {
        IDLE,
        S_RD,
        S_GO,
        S_WAIT,
        S_ACK,
        AVG,
        B_RD,
        B_GO,
        B_WAIT,
        B_WR,
        DONE
    } state_t;

    // Byte offsets of each channel in a 24-bit {r,g,b} word.
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    localparam int DEFAULT_WAIT_MAX = 255;

    function automatic logic [7:0] chan(input logic [23:0] rgb, input int lsb);
        return rgb[lsb +: 8];
    endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Handshake bundle between the sequencer (master) and one background-removal pe (slave).
// Carries pixel/expected colour/threshold/replacement colour towards the pe,
// start pulses and acknowledge, and the pe done states plus its sum/pixel results.
interface pe_sequencer_if;
    logic [23:0] pe_rgb_in;
    logic [23:0] pe_exp;
    logic [7:0]  pe_threshold;
    logic [23:0] pe_desired_bg;
    logic        pe_Start_Sum;
    logic        pe_Start_BgRemoval;
    logic        pe_Ack;
    logic        pe_Qsd;
    logic        pe_Qbgd;
    logic [23:0] pe_sum;
    logic [23:0] pe_rgb_out;

    modport master (
        output pe_rgb_in, pe_exp, pe_threshold, pe_desired_bg,
        output pe_Start_Sum, pe_Start_BgRemoval, pe_Ack,
        input  pe_Qsd, pe_Qbgd, pe_sum, pe_rgb_out
    );

    modport slave (
        input  pe_rgb_in, pe_exp, pe_threshold, pe_desired_bg,
        input  pe_Start_Sum, pe_Start_BgRemoval, pe_Ack,
        output pe_Qsd, pe_Qbgd, pe_sum, pe_rgb_out
    );
endinterface

// File: rtl/pe_sequencer_accum.sv
// Three per-channel sum accumulators with synchronous clear/add and a floor-average output.
// Latency: add/clear take effect on the next edge; avg_out is combinational from the accumulators.
// Ports: clk/rst_n, clr, add, sum_in {r,g,b}, avg_out {r,g,b} = acc >> LOG2_NPIX.
module pe_rgb_accum
    import pe_defs::*;
#(
    parameter int LOG2_NPIX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [23:0] sum_in,
    output logic [23:0] avg_out
);
    // 8 + LOG2_NPIX bits holds NPIX bytes of 255 without overflow.
    localparam int AW = 8 + LOG2_NPIX;

    logic [AW-1:0] acc_r, acc_g, acc_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (clr) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (add) begin
            acc_r <= acc_r + AW'(chan(sum_in, R_LSB));
            acc_g <= acc_g + AW'(chan(sum_in, G_LSB));
            acc_b <= acc_b + AW'(chan(sum_in, B_LSB));
        end
    end

    assign avg_out = {8'(acc_r >> LOG2_NPIX), 8'(acc_g >> LOG2_NPIX), 8'(acc_b >> LOG2_NPIX)};

endmodule

// File: rtl/pe_sequencer.sv
// Drives one background-removal pe over a frame: pass 1 sums pixels into per-channel
// averages, pass 2 re-streams pixels against those averages and writes pe results out.
// Latency >= 4 cycles/pixel/pass (RD, GO, WAIT >= 1, ACK/WR); waits on pe done with a WAIT_MAX timeout.
// Ports: Clk/Reset_n, Go/Busy/Done/Err, pixel read port, output write port, avg_rgb, pe master bundle.
module pe_sequencer
    import pe_defs::*;
#(
    parameter int LOG2_NPIX = 4,
    parameter int WAIT_MAX  = DEFAULT_WAIT_MAX
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Go,
    input  logic [7:0]           threshold,
    input  logic [23:0]          desired_bg,
    output logic [LOG2_NPIX-1:0] pix_addr,
    input  logic [23:0]          pix_rdata,
    output logic                 out_we,
    output logic [LOG2_NPIX-1:0] out_addr,
    output logic [23:0]          out_wdata,
    output logic [23:0]          avg_rgb,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err,
    pe_sequencer_if.master       pe
);
    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0]       WAIT_LAST = WCW'(WAIT_MAX - 1);
    localparam logic [LOG2_NPIX-1:0] IDX_LAST  = '1;

    state_t               state;
    logic [LOG2_NPIX-1:0] idx;
    logic [WCW-1:0]       wait_cnt;
    logic [23:0]          rgb_in_q;
    logic [23:0]          avg_q;
    logic                 start_sum_q, start_bg_q, ack_q;
    logic [23:0]          acc_avg;
    logic                 acc_clr, acc_add;

    // Accumulators clear on the same Go edge that launches a frame.
    assign acc_clr = ((state == IDLE) || (state == DONE)) && Go;
    assign acc_add = (state == S_WAIT) && pe.pe_Qsd;

    pe_rgb_accum #(.LOG2_NPIX(LOG2_NPIX)) u_accum (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .clr    (acc_clr),
        .add    (acc_add),
        .sum_in (pe.pe_sum),
        .avg_out(acc_avg)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            pix_addr    <= '0;
            rgb_in_q    <= '0;
            avg_q       <= '0;
            start_sum_q <= 1'b0;
            start_bg_q  <= 1'b0;
            ack_q       <= 1'b0;
            out_we      <= 1'b0;
            out_addr    <= '0;
            out_wdata   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Err         <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            start_sum_q <= 1'b0;
            start_bg_q  <= 1'b0;
            ack_q       <= 1'b0;
            out_we      <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Go) begin
                        idx      <= '0;
                        pix_addr <= '0;
                        Err      <= 1'b0;
                        Done     <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= S_RD;
                    end
                end
                // pix_addr is already presented on entry; read data lands during *_GO.
                S_RD: state <= S_GO;
                S_GO: begin
                    rgb_in_q    <= pix_rdata;
                    start_sum_q <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe.pe_Qsd) begin
                        ack_q <= 1'b1;
                        state <= S_ACK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Err   <= 1'b1;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (idx == IDX_LAST) begin
                        state <= AVG;
                    end else begin
                        idx      <= idx + 1'b1;
                        pix_addr <= idx + 1'b1;
                        state    <= S_RD;
                    end
                end
                AVG: begin
                    avg_q    <= acc_avg;
                    idx      <= '0;
                    pix_addr <= '0;
                    state    <= B_RD;
                end
                B_RD: state <= B_GO;
                B_GO: begin
                    rgb_in_q   <= pix_rdata;
                    start_bg_q <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= B_WAIT;
                end
                B_WAIT: begin
                    if (pe.pe_Qbgd) begin
                        out_we    <= 1'b1;
                        out_addr  <= idx;
                        out_wdata <= pe.pe_rgb_out;
                        ack_q     <= 1'b1;
                        state     <= B_WR;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Err   <= 1'b1;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                B_WR: begin
                    if (idx == IDX_LAST) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        pix_addr <= idx + 1'b1;
                        state    <= B_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign avg_rgb                = avg_q;
    assign pe.pe_exp              = avg_q;
    assign pe.pe_rgb_in           = rgb_in_q;
    assign pe.pe_Start_Sum        = start_sum_q;
    assign pe.pe_Start_BgRemoval  = start_bg_q;
    assign pe.pe_Ack              = ack_q;
    assign pe.pe_threshold        = threshold;
    assign pe.pe_desired_bg       = desired_bg;

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer with NPIX=4, WAIT_MAX=8 and a behavioural pe:
// sum returns the pixel, bg-removal replaces a pixel within threshold of exp on all channels.
module tb_pe_sequencer;
    localparam int L2 = 2;
    localparam int NP = 4;
    localparam int WM = 8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Go = 1'b0;
    logic [7:0]  threshold = 8'd30;
    logic [23:0] desired_bg = 24'h0A0A0A;
    logic [1:0]  pix_addr;
    logic [23:0] pix_rdata;
    logic        out_we;
    logic [1:0]  out_addr;
    logic [23:0] out_wdata;
    logic [23:0] avg_rgb;
    logic        Busy, Done, Err;

    pe_sequencer_if pe_bus();

    pe_sequencer #(.LOG2_NPIX(L2), .WAIT_MAX(WM)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .threshold(threshold), .desired_bg(desired_bg),
        .pix_addr(pix_addr), .pix_rdata(pix_rdata), .out_we(out_we), .out_addr(out_addr),
        .out_wdata(out_wdata), .avg_rgb(avg_rgb), .Busy(Busy), .Done(Done), .Err(Err),
        .pe(pe_bus)
    );

    always #5 Clk = ~Clk;

    // Frame memory with one-cycle read latency.
    logic [23:0] mem [NP];
    always @(posedge Clk) pix_rdata <= mem[pix_addr];

    // ---------------- behavioural pe ----------------
    int          lat = 1;
    bit          never_done = 1'b0;
    logic        pend, is_bg, qsd, qbgd;
    int          cnt;
    logic [23:0] px, ex, sum_o, rgb_o;

    function automatic logic [23:0] bg_rule(input logic [23:0] p, input logic [23:0] e,
                                            input logic [23:0] bg, input logic [7:0] th);
        bit near = 1'b1;
        for (int c = 0; c < 3; c++) begin
            int a = int'(p[c*8 +: 8]);
            int b = int'(e[c*8 +: 8]);
            int d = (a > b) ? a - b : b - a;
            if (d > int'(th)) near = 1'b0;
        end
        return near ? bg : p;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend <= 1'b0; is_bg <= 1'b0; cnt <= 0; px <= '0; ex <= '0;
            qsd <= 1'b0; qbgd <= 1'b0; sum_o <= '0; rgb_o <= '0;
        end else begin
            if (pe_bus.pe_Ack) begin
                qsd  <= 1'b0;
                qbgd <= 1'b0;
            end
            if (never_done) begin
                pend <= 1'b0;
            end else if (pe_bus.pe_Start_Sum || pe_bus.pe_Start_BgRemoval) begin
                pend  <= 1'b1;
                is_bg <= pe_bus.pe_Start_BgRemoval;
                cnt   <= lat - 1;
                px    <= pe_bus.pe_rgb_in;
                ex    <= pe_bus.pe_exp;
            end else if (pend) begin
                if (cnt == 0) begin
                    pend <= 1'b0;
                    if (is_bg) begin
                        qbgd  <= 1'b1;
                        rgb_o <= bg_rule(px, ex, pe_bus.pe_desired_bg, pe_bus.pe_threshold);
                    end else begin
                        qsd   <= 1'b1;
                        sum_o <= px;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    assign pe_bus.pe_Qsd     = qsd;
    assign pe_bus.pe_Qbgd    = qbgd;
    assign pe_bus.pe_sum     = sum_o;
    assign pe_bus.pe_rgb_out = rgb_o;

    // ---------------- bus monitor ----------------
    int          wr_cnt = 0, ack_cnt = 0, ack_bad = 0, start_bad = 0, start_long = 0;
    logic        prev_start = 1'b0;
    logic [1:0]  wr_addr_log [64];
    logic [23:0] wr_data_log [64];

    always @(posedge Clk) begin
        if (out_we) begin
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] <= out_addr;
                wr_data_log[wr_cnt] <= out_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (pe_bus.pe_Ack) begin
            ack_cnt <= ack_cnt + 1;
            if (!(qsd || qbgd)) ack_bad <= ack_bad + 1;
        end
        if (pe_bus.pe_Start_Sum || pe_bus.pe_Start_BgRemoval) begin
            if (qsd || qbgd) start_bad <= start_bad + 1;
            if (prev_start) start_long <= start_long + 1;
        end
        prev_start <= pe_bus.pe_Start_Sum || pe_bus.pe_Start_BgRemoval;
    end

    // ---------------- stimulus ----------------
    int errors = 0;
    int checks = 0;

    logic [23:0] pat_uni [NP];
    logic [23:0] pat_mix [NP];
    logic [23:0] exp_mix [NP];

    task automatic pulse_go();
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!Done && n < budget) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic load(input int which);
        for (int i = 0; i < NP; i++) mem[i] = (which == 0) ? pat_uni[i] : pat_mix[i];
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (pix_addr !== 2'd0)   begin errors++; $display("FAIL rst_pix_addr: got %h want 0", pix_addr); end
        checks++; if (avg_rgb !== 24'h0)   begin errors++; $display("FAIL rst_avg: got %h want 0", avg_rgb); end
        checks++; if ({out_we, Busy, Done, Err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {out_we, Busy, Done, Err}); end
        checks++; if ({pe_bus.pe_Start_Sum, pe_bus.pe_Start_BgRemoval, pe_bus.pe_Ack} !== 3'b0) begin errors++; $display("FAIL rst_pe_ctl: got %b want 000", {pe_bus.pe_Start_Sum, pe_bus.pe_Start_BgRemoval, pe_bus.pe_Ack}); end
        checks++; if ({pe_bus.pe_rgb_in, pe_bus.pe_exp} !== 48'h0) begin errors++; $display("FAIL rst_pe_data: got %h want 0", {pe_bus.pe_rgb_in, pe_bus.pe_exp}); end
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL idle_no_go: got %b want 00", {Busy, Done}); end
    endtask

    task automatic test_uniform();
        int n; int base;
        load(0);
        base = wr_cnt;
        pulse_go();
        wait_done(400, n);
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL uni_done: got %b want 1", Done); end
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL uni_err: got %b want 0", Err); end
        checks++; if (avg_rgb !== 24'h3D85C6) begin errors++; $display("FAIL uni_avg: got %h want 3d85c6", avg_rgb); end
        checks++; if (pe_bus.pe_exp !== 24'h3D85C6) begin errors++; $display("FAIL uni_exp: got %h want 3d85c6", pe_bus.pe_exp); end
        checks++; if (wr_cnt - base !== NP) begin errors++; $display("FAIL uni_nwr: got %0d want %0d", wr_cnt - base, NP); end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (wr_addr_log[base+i] !== 2'(i) || wr_data_log[base+i] !== 24'h0A0A0A) begin
                errors++;
                $display("FAIL uni_wr[%0d]: got addr %0d data %h want addr %0d data 0a0a0a", i, wr_addr_log[base+i], wr_data_log[base+i], i);
            end
        end
    endtask

    task automatic test_mixed();
        int n; int base; int a0;
        load(1);
        base = wr_cnt; a0 = ack_cnt;
        pulse_go();
        wait_done(400, n);
        checks++; if ({Done, Err} !== 2'b10) begin errors++; $display("FAIL mix_done_err: got %b want 10", {Done, Err}); end
        checks++; if (avg_rgb !== 24'h5F6899) begin errors++; $display("FAIL mix_avg: got %h want 5f6899", avg_rgb); end
        checks++; if (wr_cnt - base !== NP) begin errors++; $display("FAIL mix_nwr: got %0d want %0d", wr_cnt - base, NP); end
        checks++; if (ack_cnt - a0 !== 2*NP) begin errors++; $display("FAIL mix_nack: got %0d want %0d", ack_cnt - a0, 2*NP); end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (wr_addr_log[base+i] !== 2'(i) || wr_data_log[base+i] !== exp_mix[i]) begin
                errors++;
                $display("FAIL mix_wr[%0d]: got addr %0d data %h want addr %0d data %h", i, wr_addr_log[base+i], wr_data_log[base+i], i, exp_mix[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n; int base; int a0;
        load(0);
        never_done = 1'b1;
        base = wr_cnt; a0 = ack_cnt;
        pulse_go();
        wait_done(100, n);
        checks++; if ({Done, Err} !== 2'b11) begin errors++; $display("FAIL to_done_err: got %b want 11", {Done, Err}); end
        checks++; if (n !== 10) begin errors++; $display("FAIL to_cycles: got %0d want 10", n); end
        repeat (3) @(negedge Clk);
        checks++; if (wr_cnt - base !== 0 || ack_cnt - a0 !== 0) begin errors++; $display("FAIL to_quiet: got wr %0d ack %0d want 0 0", wr_cnt - base, ack_cnt - a0); end
        // Go from DONE clears Err and runs a full frame.
        never_done = 1'b0;
        pulse_go();
        checks++; if ({Err, Busy, Done} !== 3'b010) begin errors++; $display("FAIL to_restart: got %b want 010", {Err, Busy, Done}); end
        wait_done(400, n);
        checks++; if ({Done, Err} !== 2'b10 || wr_cnt - base !== NP) begin errors++; $display("FAIL to_recover: got done/err %b wr %0d want 10 %0d", {Done, Err}, wr_cnt - base, NP); end
    endtask

    task automatic test_reset_midframe();
        int n; int base;
        load(0);
        base = wr_cnt;
        pulse_go();
        n = 0;
        while (wr_cnt - base < 2 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL mr_two_writes: got %0d want 2", wr_cnt - base); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if ({out_we, Busy, Done, Err, pe_bus.pe_Ack} !== 5'b0) begin errors++; $display("FAIL mr_flags: got %b want 00000", {out_we, Busy, Done, Err, pe_bus.pe_Ack}); end
        checks++; if ({avg_rgb, pe_bus.pe_rgb_in} !== 48'h0 || pix_addr !== 2'd0) begin errors++; $display("FAIL mr_data: got avg %h rgb_in %h addr %0d want 0", avg_rgb, pe_bus.pe_rgb_in, pix_addr); end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (6) @(negedge Clk);
        checks++; if (wr_cnt - base !== 2 || Busy !== 1'b0) begin errors++; $display("FAIL mr_quiet: got wr %0d busy %b want 2 0", wr_cnt - base, Busy); end
        base = wr_cnt;
        pulse_go();
        wait_done(400, n);
        checks++; if ({Done, Err} !== 2'b10 || avg_rgb !== 24'h3D85C6) begin errors++; $display("FAIL mr_frame: got done/err %b avg %h want 10 3d85c6", {Done, Err}, avg_rgb); end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (wr_cnt - base !== NP || wr_addr_log[base+i] !== 2'(i)) begin
                errors++;
                $display("FAIL mr_wr[%0d]: got n %0d addr %0d want n %0d addr %0d", i, wr_cnt - base, wr_addr_log[base+i], NP, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n; int base;
        load(1);
        base = wr_cnt;
        pulse_go();
        repeat (10) @(negedge Clk);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", Busy); end
        pulse_go();
        wait_done(400, n);
        checks++; if (wr_cnt - base !== NP) begin errors++; $display("FAIL b2b_nwr: got %0d want %0d", wr_cnt - base, NP); end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (wr_addr_log[base+i] !== 2'(i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, wr_addr_log[base+i], i); end
        end
        base = wr_cnt;
        pulse_go();
        wait_done(400, n);
        checks++; if ({Done, Err} !== 2'b10 || avg_rgb !== 24'h5F6899) begin errors++; $display("FAIL b2b_second: got done/err %b avg %h want 10 5f6899", {Done, Err}, avg_rgb); end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (wr_cnt - base !== NP || wr_data_log[base+i] !== exp_mix[i]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got n %0d data %h want n %0d data %h", i, wr_cnt - base, wr_data_log[base+i], NP, exp_mix[i]);
            end
        end
    endtask

    task automatic test_slow_pe();
        int n; int base; int a0; int sb; int sl; int ab;
        load(1);
        lat = 5;
        base = wr_cnt; a0 = ack_cnt; sb = start_bad; sl = start_long; ab = ack_bad;
        pulse_go();
        wait_done(600, n);
        checks++; if ({Done, Err} !== 2'b10) begin errors++; $display("FAIL slow_done_err: got %b want 10", {Done, Err}); end
        checks++; if (wr_cnt - base !== NP || ack_cnt - a0 !== 2*NP) begin errors++; $display("FAIL slow_counts: got wr %0d ack %0d want %0d %0d", wr_cnt - base, ack_cnt - a0, NP, 2*NP); end
        checks++; if (start_long - sl !== 0) begin errors++; $display("FAIL slow_start_pulse: got %0d long pulses want 0", start_long - sl); end
        checks++; if (start_bad - sb !== 0) begin errors++; $display("FAIL slow_start_while_done: got %0d want 0", start_bad - sb); end
        checks++; if (ack_bad - ab !== 0) begin errors++; $display("FAIL slow_ack_no_done: got %0d want 0", ack_bad - ab); end
        checks++; if (wr_data_log[base+3] !== 24'hC81414) begin errors++; $display("FAIL slow_last_data: got %h want c81414", wr_data_log[base+3]); end
        lat = 1;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            pat_uni[i] = 24'h3D85C6;
            pat_mix[i] = (i == 3) ? 24'hC81414 : 24'h3D85C6;
            exp_mix[i] = (i == 3) ? 24'hC81414 : 24'h3D85C6;
        end
        load(0);
        test_reset();
        test_uniform();
        test_mixed();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_slow_pe();
        checks++; if (ack_bad !== 0 || start_bad !== 0 || start_long !== 0) begin errors++; $display("FAIL protocol_total: got ack_bad %0d start_bad %0d start_long %0d want 0 0 0", ack_bad, start_bad, start_long); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Initiator that drives one background-removal processing element (pe) through a whole frame of NPIX pixels.
- Pass 1 (sum): streams every pixel into pe with Start_Sum, accumulates the pe sums and computes per-channel average colour.
- Pass 2 (remove): streams every pixel again with Start_BgRemoval, using the averages as red/green/blue_exp, and writes pe results to an output pixel memory.
- Sits between frame pixel memory and pe; top level asserts Go and reads Done/Err.

Parameters:
- LOG2_NPIX, 4, log2 of pixels per frame (NPIX = 2**LOG2_NPIX).
- WAIT_MAX, 255, max cycles to wait for a pe done state before error.

Ports:
- Clk  in  1  clock, all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Go  in  1  start frame; sampled only in IDLE.
- threshold  in  8  passed to pe.
- desired_bg  in  24  {r,g,b} replacement colour passed to pe.
- pix_addr  out  LOG2_NPIX  input memory read address.
- pix_rdata  in  24  {r,g,b}; valid 1 cycle after pix_addr.
- out_we  out  1  output memory write strobe, 1 cycle.
- out_addr  out  LOG2_NPIX  output write address.
- out_wdata  out  24  {red_out,green_out,blue_out} from pe.
- pe_rgb_in  out  24  pixel to pe (red_in/green_in/blue_in).
- pe_exp  out  24  {red_exp,green_exp,blue_exp}.
- pe_Start_Sum  out  1  one-cycle pulse.
- pe_Start_BgRemoval  out  1  one-cycle pulse.
- pe_Ack  out  1  one-cycle acknowledge of a pe done state.
- pe_Qsd  in  1  pe sum-done state.
- pe_Qbgd  in  1  pe bg-removal-done state.
- pe_sum  in  24  {red_sum,green_sum,blue_sum}.
- pe_rgb_out  in  24  {red_out,green_out,blue_out}.
- avg_rgb  out  24  computed averages (holds after frame).
- Busy  out  1  high outside IDLE/DONE.
- Done  out  1  high in DONE until next Go.
- Err  out  1  set on timeout, cleared on Go.

Behaviour:
- Reset: state IDLE; all outputs 0, including pix_addr, avg_rgb, Err and the accumulators. Reset mid-frame aborts immediately; no further out_we.
- States: IDLE, S_RD, S_GO, S_WAIT, S_ACK, AVG, B_RD, B_GO, B_WAIT, B_WR, DONE.
- IDLE: on Go, idx=0, clear accumulators and Err, go to S_RD.
- S_RD: pix_addr=idx; next cycle latch pix_rdata into pe_rgb_in.
- S_GO: pe_Start_Sum=1 for exactly 1 cycle.
- S_WAIT: wait for pe_Qsd, then add each pe_sum byte into its own accumulator (8+LOG2_NPIX bits, no overflow possible).
- S_ACK: pe_Ack=1 for 1 cycle. If idx==NPIX-1, go to AVG; else idx++ and go to S_RD.
- AVG: avg = acc >> LOG2_NPIX (floor) per channel, registered into avg_rgb and pe_exp. idx=0.
- B_RD / B_GO / B_WAIT: same as pass 1 but pulse pe_Start_BgRemoval and wait for pe_Qbgd. threshold and desired_bg are forwarded combinationally throughout.
- B_WR: out_we=1, out_addr=idx, out_wdata=pe_rgb_out, pe_Ack=1 in the same cycle. After the last idx go to DONE; else idx++ and go to B_RD.
- Timing: pe_Ack is never asserted unless the matching done input is high. Start pulses are never issued while pe_Qsd or pe_Qbgd is high.
- Timeout: wait counter resets on entry to each WAIT state. When it reaches WAIT_MAX without the done input, set Err and go to DONE with no further writes or Ack.
- DONE: Done=1, Busy=0. Go returns to the IDLE flow (restarts the frame). Go while Busy is ignored.
- Minimum per-pixel cycles: RD 1 + GO 1 + WAIT (pe latency, at least 1) + ACK/WR 1.

Decomposition:
- Shared package pe_defs: state encoding constants, channel byte offsets (R=[23:16], G=[15:8], B=[7:0]), default WAIT_MAX.
- One natural sub-module: pe_rgb_accum, three channel accumulators with clear/add and a shift-average output.

Test Plan:
- Real pe, LOG2_NPIX=2, four pixels (61,133,198), threshold 30, desired_bg (10,10,10), Go pulse -> avg_rgb=(61,133,198); 4 out_we at addresses 0..3, each wdata (10,10,10); then Done=1, Err=0.
- Pixels (61,133,198)x3 plus (200,20,20) -> avg_rgb=(95,104,153) (floor); exactly 4 writes; exactly 8 Ack pulses over the frame.
- pe stub never raises Qsd, WAIT_MAX=8 -> Err=1 and Done=1 within 8 wait cycles; no out_we, no pe_Ack.
- Reset_n low during pass 2 after 2 writes -> all outputs 0 immediately; no further writes; a new Go completes a full frame.
- Go re-pulsed while Busy -> ignored, with exactly NPIX writes; Go in DONE -> second frame with identical outputs.
- pe stub with 5-cycle done latency -> each Start is a single-cycle pulse, Ack occurs only while the done input is high, and no Start is issued while a done input is high.
